// File: rtl/ps2_host_tx.sv
// ps2_host_tx
//
// Host-to-device PS/2 transmitter. It sends one command byte to the keyboard,
// for example 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset). The shared
// open-drain ps2_clk/ps2_data lines are driven only through drive-low enables.
// The top level builds the actual tristate buffers.
//
// Sequence for one byte:
//   1. Hold ps2_clk low for INHIBIT_CYCLES system clocks.
//   2. Pull ps2_data low (start bit) and release ps2_clk.
//   3. The device then clocks out the frame. On each device clock falling
//      edge, the host presents the next bit: data bits LSB first, odd parity,
//      then stop.
//   4. The device acknowledges by pulling ps2_data low on the 11th clock.
//
// Ports
//   clock               system clock; all logic is on its rising edge
//   reset               asynchronous, active-low reset
//   tx_valid/tx_data    command byte request; accepted when tx_valid && tx_ready
//   tx_ready            high while idle and able to accept a byte
//   busy                high from acceptance until the FSM is idle again
//   tx_done             one-cycle pulse: byte acknowledged by the device
//   tx_error            one-cycle pulse: timeout or missing ACK
//   ps2_clk_in          raw ps2_clk line level
//   ps2_data_in         raw ps2_data line level
//   ps2_clk_drive_low   1 pulls ps2_clk low, 0 releases it
//   ps2_data_drive_low  1 pulls ps2_data low, 0 releases it

module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [INH_W-1:0] INH_LAST  = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [INH_W-1:0] INH_START = INH_W'(INHIBIT_CYCLES - 2);
    localparam logic [TO_W-1:0]  TO_LIMIT  = TO_W'(TIMEOUT_CYCLES);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_REQ       = 3'd2;
    localparam logic [2:0] S_SEND      = 3'd3;
    localparam logic [2:0] S_ACK       = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;

    logic [1:0]       r_clkSync;
    logic [1:0]       r_dataSync;
    logic             r_clkPrev;
    logic [2:0]       r_state;
    logic [9:0]       r_shift;
    logic [3:0]       r_bitCnt;
    logic [INH_W-1:0] r_inhCnt;
    logic [TO_W-1:0]  r_toCnt;
    logic             r_clkDrive;
    logic             r_dataDrive;
    logic             r_txDone;
    logic             r_txError;

    logic w_clkS;
    logic w_dataS;
    logic w_fe;
    logic w_idle;
    logic w_accept;
    logic w_timeout;

    // Two-stage synchronizers for both bus lines.
    // They reset to 1, the idle bus level, so leaving reset never produces
    // a spurious falling edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_clkSync  <= 2'b11;
            r_dataSync <= 2'b11;
            r_clkPrev  <= 1'b1;
        end else begin
            r_clkSync  <= {r_clkSync[0], ps2_clk_in};
            r_dataSync <= {r_dataSync[0], ps2_data_in};
            r_clkPrev  <= r_clkSync[1];
        end
    end

    assign w_clkS  = r_clkSync[1];
    assign w_dataS = r_dataSync[1];
    assign w_fe    = r_clkPrev & ~w_clkS;

    // The pulse cycle still counts as busy.
    // A new byte can therefore only be taken the cycle after done/error.
    assign w_idle    = (r_state == S_IDLE);
    assign tx_ready  = w_idle & ~r_txDone & ~r_txError;
    assign busy      = ~tx_ready;
    assign w_accept  = tx_valid & tx_ready;
    assign w_timeout = (r_toCnt == TO_LIMIT);

    assign tx_done            = r_txDone;
    assign tx_error           = r_txError;
    assign ps2_clk_drive_low  = r_clkDrive;
    assign ps2_data_drive_low = r_dataDrive;

    // Transfer FSM.
    // Bits leave the LSB end of a right-shifting frame register, so each
    // device clock falling edge presents r_shift[0].
    // The timeout counter is shared by every state that waits on the device:
    //   - a falling edge always clears it, even when it hits the limit in the
    //     same cycle;
    //   - otherwise it stops at the limit, which raises the error.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_bitCnt    <= '0;
            r_inhCnt    <= '0;
            r_toCnt     <= '0;
            r_clkDrive  <= 1'b0;
            r_dataDrive <= 1'b0;
            r_txDone    <= 1'b0;
            r_txError   <= 1'b0;
        end else begin
            r_txDone  <= 1'b0;
            r_txError <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shift     <= {1'b1, ~^tx_data, tx_data};
                        r_inhCnt    <= '0;
                        r_clkDrive  <= 1'b1;
                        r_dataDrive <= (INHIBIT_CYCLES == 1);
                        r_state     <= S_INHIBIT;
                    end
                end

                S_INHIBIT: begin
                    // Start bit goes low during the final inhibit cycle.
                    if (r_inhCnt == INH_START) begin
                        r_dataDrive <= 1'b1;
                    end
                    if (r_inhCnt == INH_LAST) begin
                        r_clkDrive <= 1'b0;
                        r_toCnt    <= '0;
                        r_state    <= S_REQ;
                    end else begin
                        r_inhCnt <= r_inhCnt + 1'b1;
                    end
                end

                S_REQ, S_SEND, S_ACK, S_WAIT_IDLE: begin
                    if (w_fe) begin
                        r_toCnt <= '0;
                    end else if (!w_timeout) begin
                        r_toCnt <= r_toCnt + 1'b1;
                    end

                    if (r_state == S_WAIT_IDLE) begin
                        if (w_clkS && w_dataS) begin
                            r_txDone <= 1'b1;
                            r_state  <= S_IDLE;
                        end else if (!w_fe && w_timeout) begin
                            r_clkDrive  <= 1'b0;
                            r_dataDrive <= 1'b0;
                            r_txError   <= 1'b1;
                            r_toCnt     <= '0;
                            r_state     <= S_IDLE;
                        end
                    end else if (w_fe) begin
                        if (r_state == S_REQ) begin
                            r_dataDrive <= ~r_shift[0];
                            r_shift     <= {1'b0, r_shift[9:1]};
                            r_bitCnt    <= 4'd1;
                            r_state     <= S_SEND;
                        end else if (r_state == S_SEND) begin
                            // Count 9 presents the stop bit, which releases
                            // the data line.
                            r_dataDrive <= ~r_shift[0];
                            r_shift     <= {1'b0, r_shift[9:1]};
                            r_bitCnt    <= r_bitCnt + 1'b1;
                            if (r_bitCnt == 4'd9) begin
                                r_state <= S_ACK;
                            end
                        end else begin
                            // The device ACKs by holding data low on the
                            // 11th clock.
                            r_dataDrive <= 1'b0;
                            if (!w_dataS) begin
                                r_state <= S_WAIT_IDLE;
                            end else begin
                                r_txError <= 1'b1;
                                r_state   <= S_IDLE;
                            end
                        end
                    end else if (w_timeout) begin
                        r_clkDrive  <= 1'b0;
                        r_dataDrive <= 1'b0;
                        r_txError   <= 1'b1;
                        r_toCnt     <= '0;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_clkDrive  <= 1'b0;
                    r_dataDrive <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps

// Testbench for ps2_host_tx.
// A small PS/2 device model clocks frames out of the host and records the
// bits it samples. Those bits are compared with the frame computed from the
// byte: data LSB first, odd parity, stop. A per-cycle monitor checks:
//   - the inhibit window;
//   - the start bit;
//   - line release while idle;
//   - the done/error pulses.
module tb_ps2_host_tx;

    localparam int IC = 40;
    localparam int TO = 1500;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready;
    logic       busy;
    logic       tx_done;
    logic       tx_error;
    logic       ps2_clk_drive_low;
    logic       ps2_data_drive_low;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       devClkLow = 1'b0;
    logic       devDataLow = 1'b0;

    int checks = 0;
    int errors = 0;

    int cycNeg = 0;
    int acceptNeg = -1000000;
    int errorNeg = 0;
    int doneCnt = 0;
    int errCnt = 0;
    int clkRun = 0;
    int lastRun = 0;
    logic [7:0] acceptQ[$];

    // Open-drain wired-AND of host and device.
    assign ps2_clk_in  = ~(ps2_clk_drive_low | devClkLow);
    assign ps2_data_in = ~(ps2_data_drive_low | devDataLow);

    ps2_host_tx #(
        .INHIBIT_CYCLES(IC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .tx_valid           (tx_valid),
        .tx_data            (tx_data),
        .tx_ready           (tx_ready),
        .busy               (busy),
        .tx_done            (tx_done),
        .tx_error           (tx_error),
        .ps2_clk_in         (ps2_clk_in),
        .ps2_data_in        (ps2_data_in),
        .ps2_clk_drive_low  (ps2_clk_drive_low),
        .ps2_data_drive_low (ps2_data_drive_low)
    );

    always #5 clock = ~clock;

    // Watchdog: the run must never hang.
    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation did not finish, actual timeout, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
        end
    endtask

    // Reference frame as the device must see it.
    // Parity comes from counting ones, not from a reduction operator.
    function automatic logic [9:0] frameOf(input logic [7:0] b);
        logic [9:0] f;
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[i] = b[i];
            if (b[i]) ones++;
        end
        f[8] = ((ones % 2) == 0);
        f[9] = 1'b1;
        return f;
    endfunction

    // Per-cycle compare process.
    always @(negedge clock) begin
        cycNeg++;
        if (!reset) begin
            acceptNeg = -1000000;
            clkRun = 0;
        end else begin
            checkOutput("clk_inhibit_window", 32'(ps2_clk_drive_low),
                        32'((cycNeg > acceptNeg) && (cycNeg <= acceptNeg + IC)));
            if (cycNeg == acceptNeg + IC)
                checkOutput("start_bit_last_inhibit", 32'(ps2_data_drive_low), 32'd1);
            if (!busy)
                checkOutput("idle_data_released", 32'(ps2_data_drive_low), 32'd0);
            checkOutput("done_error_exclusive", 32'(tx_done & tx_error), 32'd0);
            if (ps2_clk_drive_low) begin
                clkRun++;
            end else if (clkRun != 0) begin
                lastRun = clkRun;
                clkRun = 0;
            end
            if (tx_done) doneCnt++;
            if (tx_error) begin
                errCnt++;
                errorNeg = cycNeg;
            end
            if (tx_valid && tx_ready) begin
                acceptNeg = cycNeg;
                acceptQ.push_back(tx_data);
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] b);
        int n;
        n = 0;
        @(posedge clock); #1;
        while (!tx_ready && n < 5000) begin
            @(posedge clock); #1;
            n++;
        end
        checkOutput("ready_before_request", 32'(tx_ready), 32'd1);
        tx_valid = 1'b1;
        tx_data  = b;
        @(posedge clock); #1;
        tx_valid = 1'b0;
    endtask

    // Device model. It waits for the host request, then generates up to 11
    // clocks with half period hp, sampling data on each rising edge.
    // With ack=1 it holds data low across the 11th clock.
    // abortFe>0 stops with the clock held low right after that falling edge.
    task automatic deviceTransfer(input int hp, input bit ack, input int abortFe,
                                  output logic [9:0] got, output bit reqSeen);
        int n;
        got = '0;
        n = 0;
        while (!(ps2_clk_drive_low == 1'b0 && ps2_data_drive_low == 1'b1) && n < IC + 100) begin
            @(negedge clock);
            n++;
        end
        reqSeen = (ps2_clk_drive_low == 1'b0 && ps2_data_drive_low == 1'b1);
        if (!reqSeen) return;
        repeat (5) @(negedge clock);
        for (int i = 0; i < 11; i++) begin
            if (i == 10 && ack) begin
                devDataLow = 1'b1;
                repeat (3) @(negedge clock);
            end
            devClkLow = 1'b1;
            if (i + 1 == abortFe) begin
                repeat (4) @(negedge clock);
                return;
            end
            repeat (hp) @(negedge clock);
            devClkLow = 1'b0;
            repeat (2) @(negedge clock);
            if (i < 10) got[i] = ps2_data_in;
            repeat (hp - 2) @(negedge clock);
        end
        devDataLow = 1'b0;
    endtask

    task automatic runTransfer(input logic [7:0] b, input int hp, input bit ack,
                               input string tag, output logic [9:0] got);
        bit req;
        int d0;
        int e0;
        d0 = doneCnt;
        e0 = errCnt;
        applyStimulus(b);
        deviceTransfer(hp, ack, 0, got, req);
        checkOutput({tag, "_request_seen"}, 32'(req), 32'd1);
        checkOutput({tag, "_frame_model"}, 32'(got), 32'(frameOf(b)));
        repeat (20) @(negedge clock);
        checkOutput({tag, "_done_pulses"}, 32'(doneCnt - d0), ack ? 32'd1 : 32'd0);
        checkOutput({tag, "_error_pulses"}, 32'(errCnt - e0), ack ? 32'd0 : 32'd1);
        checkOutput({tag, "_inhibit_width"}, 32'(lastRun), 32'(IC));
        checkOutput({tag, "_ready_after"}, 32'(tx_ready), 32'd1);
    endtask

    initial begin
        logic [9:0] got;
        logic [7:0] rb;
        bit req;
        bit ack;
        int hp;
        int n;
        int d0;
        int e0;
        int a;
        int lat;
        int base;

        // Reset values while reset is held low.
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_ready", 32'(tx_ready), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(tx_done), 32'd0);
        checkOutput("reset_error", 32'(tx_error), 32'd0);
        checkOutput("reset_drives", 32'({ps2_clk_drive_low, ps2_data_drive_low}), 32'd0);
        reset = 1'b1;
        repeat (3) @(posedge clock);

        // Fixed bytes; the frames are pinned with hand-computed literals.
        runTransfer(8'hED, 20, 1'b1, "ed", got);
        checkOutput("ed_frame_literal", 32'(got), 32'h3ED);
        runTransfer(8'h01, 15, 1'b1, "x01", got);
        checkOutput("x01_frame_literal", 32'(got), 32'h201);
        runTransfer(8'hFF, 12, 1'b1, "xff", got);
        checkOutput("xff_frame_literal", 32'(got), 32'h3FF);

        // NACK, then a clean 0xF4.
        runTransfer(8'h12, 18, 1'b0, "nack", got);
        runTransfer(8'hF4, 18, 1'b1, "f4_after_nack", got);
        checkOutput("f4_frame_literal", 32'(got), 32'h2F4);

        // The device never clocks, so the host must time out.
        e0 = errCnt;
        d0 = doneCnt;
        applyStimulus(8'h55);
        a = acceptNeg;
        n = 0;
        while (errCnt == e0 && n < IC + TO + 100) begin
            @(negedge clock);
            n++;
        end
        checkOutput("timeout_fired", 32'(errCnt - e0), 32'd1);
        lat = errorNeg - a - 1;
        checkOutput("timeout_latency_window", 32'((lat >= IC + TO - 2) && (lat <= IC + TO + 2)), 32'd1);
        @(negedge clock);
        checkOutput("timeout_drives_released", 32'({ps2_clk_drive_low, ps2_data_drive_low}), 32'd0);
        checkOutput("timeout_ready", 32'(tx_ready), 32'd1);
        checkOutput("timeout_no_done", 32'(doneCnt - d0), 32'd0);

        // tx_valid held with 0xAA while busy.
        // Only the first byte goes out now; 0xAA is taken only after ready
        // returns.
        base = acceptQ.size();
        d0 = doneCnt;
        @(posedge clock); #1;
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        @(posedge clock); #1;
        tx_data  = 8'hAA;
        deviceTransfer(16, 1'b1, 0, got, req);
        checkOutput("hold_first_frame", 32'(got), 32'(frameOf(8'h3C)));
        n = 0;
        while (acceptQ.size() < base + 2 && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        tx_valid = 1'b0;
        checkOutput("hold_done_before_second", 32'(doneCnt - d0), 32'd1);
        checkOutput("hold_accept_count", 32'(acceptQ.size() - base), 32'd2);
        if (acceptQ.size() >= base + 2) begin
            checkOutput("hold_first_byte", 32'(acceptQ[base]), 32'h3C);
            checkOutput("hold_second_byte", 32'(acceptQ[base + 1]), 32'hAA);
        end
        deviceTransfer(16, 1'b1, 0, got, req);
        checkOutput("hold_second_frame", 32'(got), 32'h3AA);
        repeat (20) @(negedge clock);
        checkOutput("hold_total_done", 32'(doneCnt - d0), 32'd2);

        // Asynchronous reset at falling edge 5 of an 0xFF transfer.
        d0 = doneCnt;
        e0 = errCnt;
        applyStimulus(8'hFF);
        deviceTransfer(20, 1'b1, 5, got, req);
        checkOutput("abort_bits_so_far", 32'(got[3:0]), 32'hF);
        checkOutput("abort_busy_before", 32'(busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("abort_drives_released", 32'({ps2_clk_drive_low, ps2_data_drive_low}), 32'd0);
        checkOutput("abort_busy_cleared", 32'(busy), 32'd0);
        devClkLow = 1'b0;
        repeat (3) @(negedge clock);
        @(posedge clock); #3;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput("abort_ready_after", 32'(tx_ready), 32'd1);
        checkOutput("abort_outputs_after",
                    32'({tx_done, tx_error, ps2_clk_drive_low, ps2_data_drive_low}), 32'd0);
        checkOutput("abort_no_pulses", 32'((doneCnt - d0) + (errCnt - e0)), 32'd0);

        // Randomized bytes, device speeds and ACK/NACK.
        for (int k = 0; k < 5; k++) begin
            rb  = 8'($urandom_range(0, 255));
            hp  = int'($urandom_range(8, 30));
            ack = ($urandom_range(0, 3) != 0);
            runTransfer(rb, hp, ack, "random", got);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
